safe_alu_pipe: RTL and testbench
================================

// Module: safe_alu_pipe
// PURPOSE
//  Parametrised, 2-stage pipelined successor to the 8-bit safe ALU: WIDTH-bit operands, 8 ops,
//  valid/ready flow control on both sides, N/Z/C/V flags, sticky error status and op counter.
//  Sits between an operand producer (sequencer/regfile) and a result consumer.
// PARAMETERS
//  WIDTH      8    operand/result width in bits, >=4, power of 2
//  CNT_W      16   width of accepted-op counter
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept operand beat
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (shift amount = b[$clog2(WIDTH)-1:0] for shifts)
//  opcode     in   3      operation select, see BEHAVIOUR
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result beat
//  result     out  WIDTH  result
//  zero       out  1      result == 0
//  negative   out  1      result[WIDTH-1]
//  carry      out  1      carry/borrow/shifted-out bit
//  overflow   out  1      signed overflow (ADD/SUB only)
//  illegal    out  1      opcode was reserved value
//  clr_sticky in   1      clear sticky_err
//  sticky_err out  1      set on any accepted result with overflow|illegal
//  op_count   out  CNT_W  number of accepted result beats, wraps at 2^CNT_W
// BEHAVIOUR
//  Opcodes: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 reserved.
//  Flags: ADD carry=bit WIDTH of a+b; SUB carry=borrow (a<b unsigned); SHL carry=last bit out
//   (a[WIDTH-sh]), SHR carry=a[sh-1], shift by 0 -> carry 0; logic ops carry=0.
//   overflow only for ADD/SUB (signed rule), else 0. zero/negative always from final result.
//  Reserved 111: result=0, zero=1, carry=0, overflow=0, illegal=1.
//  Pipeline: S1 registers a/b/opcode on in_valid&&in_ready; S2 registers computed result+flags.
//   Latency 2 cycles in->out with no backpressure; throughput 1 beat/cycle.
//  Ready: s2_rdy = !out_valid || out_ready; in_ready = (!s1_valid || s2_rdy) && !rst.
//   Stall holds S1/S2 contents; result/flags stable while out_valid && !out_ready.
//  Accept = out_valid && out_ready: op_count += 1 (wrap to 0); sticky_err set if overflow|illegal.
//  clr_sticky same cycle as a setting accept -> set wins (sticky_err=1 next cycle).
//  Reset: out_valid=0, result=0, all flags=0, sticky_err=0, op_count=0, S1 empty; in-flight beats
//   dropped when rst asserted mid-operation; in_ready=0 while rst high, 1 the cycle after.
// CONFIGURATION
//  SAFE_ALU_SATURATE_EN defined: ADD/SUB on signed overflow return signed max (0111..1) for
//   positive overflow, signed min (1000..0) for negative; overflow still 1, carry unchanged,
//   zero/negative from saturated result.
//  Undefined: ADD/SUB wrap modulo 2^WIDTH (original behaviour).
// STRUCTURE
//  Package safe_alu_pkg: opcode enum/localparams (OP_ADD..OP_RSVD), flag struct {z,n,c,v,ill}.
//  Sub-module safe_alu_core: purely combinational compute of result+flags from S1 regs,
//   contains the SAFE_ALU_SATURATE_EN branch; safe_alu_pipe owns handshake, regs, sticky, counter.
// TESTING (WIDTH=8, out_ready=1 unless stated)
//  ADD 10+20 -> 2 cycles later result=30, Z=0 C=0 V=0; ADD 255+1 -> result=0, Z=1 C=1 V=0.
//  ADD 0x7F+0x01 -> 0x80, V=1, N=1, sticky_err=1 after accept; with SATURATE_EN result=0x7F.
//  SUB 10-10 -> 0, Z=1 C=0; SUB 5-6 -> 0xFF, C=1 N=1; SHL 0x81 by 1 -> 0x02 C=1; SHR 0x01 by 1 -> 0, C=1 Z=1.
//  Opcode 111 -> result 0, illegal=1, sticky_err=1; clr_sticky alone -> 0; clr with setting accept -> stays 1.
//  Back-to-back 4 beats, out_ready low 3 cycles mid-stream -> in_ready drops, no loss/dup, order kept, op_count=4.
//  rst pulse with 2 beats in flight -> out_valid=0, op_count=0, next beat after reset produces correct result.

Source files
------------

// File: rtl/safe_alu_pkg.sv
// ---------------------------------------------------------------------------
// safe_alu_pkg
// Shared definitions for the pipelined safe ALU:
//   - OP_ADD .. OP_RSVD : 3-bit opcode encodings
//   - alu_flags_t       : packed flag bundle {z, n, c, v, ill}
// Optional feature macro used by this slice: SAFE_ALU_SATURATE_EN
// (see safe_alu_core).
// ---------------------------------------------------------------------------
package safe_alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    // Flag bundle carried alongside the result through the output stage.
    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
        logic ill;
    } alu_flags_t;

endpackage

// File: rtl/safe_alu_core.sv
// ---------------------------------------------------------------------------
// safe_alu_core
// Purely combinational compute of result and flags from the stage-1
// operand registers.
// Ports:
//   a, b    in  WIDTH  operands (shift amount = low $clog2(WIDTH) bits of b)
//   opcode  in  3      operation select (safe_alu_pkg::OP_*)
//   result  out WIDTH  computed result
//   flags   out        {z, n, c, v, ill}
// Macro SAFE_ALU_SATURATE_EN: when defined, ADD/SUB clamp to the signed
// max/min on signed overflow instead of wrapping.
// ---------------------------------------------------------------------------
module safe_alu_core
    import safe_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [SH_W-1:0]  sh;
    logic [WIDTH-1:0] raw_result;
    logic             carry_c;
    logic             ovf_c;
    logic             ill_c;

    assign sh = b[SH_W-1:0];

    // One extra bit on each side of the shifter captures the last bit
    // shifted out; a shift by 0 naturally leaves that bit at 0.
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign shl_ext  = {1'b0, a} << sh;
    assign shr_ext  = {a, 1'b0} >> sh;

    always_comb begin
        raw_result = '0;
        carry_c    = 1'b0;
        ovf_c      = 1'b0;
        ill_c      = 1'b0;
        case (opcode)
            OP_ADD: begin
                raw_result = sum_ext[WIDTH-1:0];
                carry_c    = sum_ext[WIDTH];
                ovf_c      = (a[WIDTH-1] == b[WIDTH-1]) &&
                             (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                raw_result = diff_ext[WIDTH-1:0];
                carry_c    = diff_ext[WIDTH];
                ovf_c      = (a[WIDTH-1] != b[WIDTH-1]) &&
                             (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: raw_result = a & b;
            OP_OR:  raw_result = a | b;
            OP_XOR: raw_result = a ^ b;
            OP_SHL: begin
                raw_result = shl_ext[WIDTH-1:0];
                carry_c    = shl_ext[WIDTH];
            end
            OP_SHR: begin
                raw_result = shr_ext[WIDTH:1];
                carry_c    = shr_ext[0];
            end
            default: ill_c = 1'b1;
        endcase
    end

`ifdef SAFE_ALU_SATURATE_EN
    // On signed overflow the sign of a tells the direction for both ADD
    // and SUB: a non-negative a can only overflow upwards.
    logic [WIDTH-1:0] sat_value;
    assign sat_value = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
    assign result    = ovf_c ? sat_value : raw_result;
`else
    assign result = raw_result;
`endif

    always_comb begin
        flags     = '0;
        flags.z   = (result == '0);
        flags.n   = result[WIDTH-1];
        flags.c   = carry_c;
        flags.v   = ovf_c;
        flags.ill = ill_c;
    end

endmodule

// File: rtl/safe_alu_pipe.sv
// ---------------------------------------------------------------------------
// safe_alu_pipe
// Two-stage pipelined safe ALU with valid/ready on both sides, N/Z/C/V
// flags, a sticky error bit and an accepted-result counter.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (a, b, opcode)
//   out_valid / out_ready result handshake (result + flags)
//   zero, negative, carry, overflow, illegal  flags of the presented result
//   clr_sticky / sticky_err  sticky overflow|illegal status
//   op_count             number of accepted results (wraps)
// Macro SAFE_ALU_SATURATE_EN: saturating ADD/SUB (in safe_alu_core).
// ---------------------------------------------------------------------------
module safe_alu_pipe
    import safe_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal,
    input  logic             clr_sticky,
    output logic             sticky_err,
    output logic [CNT_W-1:0] op_count
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             s1_adv;
    logic             s2_rdy;
    logic             accept;
    logic [WIDTH-1:0] core_result;
    alu_flags_t       core_flags;
    alu_flags_t       flags_q;

    // Stage 2 can take a new beat when empty or draining this cycle;
    // stage 1 can take one when empty or moving into stage 2.
    assign s2_rdy   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_rdy;
    assign in_ready = s1_adv && !rst;
    assign accept   = out_valid && out_ready;

    // Stage 1: capture operands; holds its contents while stage 2 stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= a;
                s1_b  <= b;
                s1_op <= opcode;
            end
        end
    end

    safe_alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (s1_a),
        .b      (s1_b),
        .opcode (s1_op),
        .result (core_result),
        .flags  (core_flags)
    );

    // Stage 2: register result and flags; frozen while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags_q   <= '0;
        end else if (s2_rdy) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result  <= core_result;
                flags_q <= core_flags;
            end
        end
    end

    assign zero     = flags_q.z;
    assign negative = flags_q.n;
    assign carry    = flags_q.c;
    assign overflow = flags_q.v;
    assign illegal  = flags_q.ill;

    // Sticky error and counter update on each accepted result; a setting
    // accept takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_err <= 1'b0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                op_count <= op_count + CNT_W'(1);
            end
            if (accept && (flags_q.v || flags_q.ill)) begin
                sticky_err <= 1'b1;
            end else if (clr_sticky) begin
                sticky_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_safe_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_safe_alu_pipe
// Directed self-checking bench for safe_alu_pipe at WIDTH=8, CNT_W=16.
// Honours SAFE_ALU_SATURATE_EN for the expected saturated results.
// ---------------------------------------------------------------------------
module tb_safe_alu_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  result;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;
    logic        illegal;
    logic        clr_sticky;
    logic        sticky_err;
    logic [15:0] op_count;

    int total;
    int bad;

    safe_alu_pipe #(
        .WIDTH (8),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .opcode     (opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .negative   (negative),
        .carry      (carry),
        .overflow   (overflow),
        .illegal    (illegal),
        .clr_sticky (clr_sticky),
        .sticky_err (sticky_err),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one beat with out_ready high, waits (bounded) for its result,
    // optionally raises clr_sticky in the accept cycle, and returns once the
    // accept has taken effect. lat = negedges from drive to result, -1 on timeout.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv,
                          input logic [2:0] top, input logic clr_at_acc,
                          output logic [7:0] r, output logic [4:0] f,
                          output int lat);
        r   = '0;
        f   = '0;
        lat = -1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        a        = ta;
        b        = tbv;
        opcode   = top;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat        = k;
                r          = result;
                f          = {zero, negative, carry, overflow, illegal};
                clr_sticky = clr_at_acc;
                break;
            end
        end
        if (lat > 0) begin
            @(negedge clk);
            clr_sticky = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_in_ready_low got=%b exp=0", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({out_valid, result, zero, negative, carry, overflow, illegal,
             sticky_err, op_count, in_ready} !== {1'b0, 8'h00, 5'b0, 1'b0, 16'h0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL reset_state got ov=%b r=%h fl=%b%b%b%b%b st=%b cnt=%0d ir=%b exp all 0, ir=1",
                     out_valid, result, zero, negative, carry, overflow, illegal,
                     sticky_err, op_count, in_ready);
        end
    endtask

    task automatic test_add();
        logic [7:0] r;
        logic [4:0] f;
        int         lat;
        // flags order: {z, n, c, v, ill}
        run_op(8'd10, 8'd20, 3'b000, 1'b0, r, f, lat);
        total++;
        if (lat !== 2) begin
            bad++;
            $display("[TB] FAIL add_latency got=%0d exp=2", lat);
        end
        total++;
        if ({r, f} !== {8'd30, 5'b00000}) begin
            bad++;
            $display("[TB] FAIL add_10_20 got r=%h f=%b exp r=1e f=00000", r, f);
        end
        run_op(8'd255, 8'd1, 3'b000, 1'b0, r, f, lat);
        total++;
        if ({r, f} !== {8'h00, 5'b10100}) begin
            bad++;
            $display("[TB] FAIL add_255_1 got r=%h f=%b exp r=00 f=10100", r, f);
        end
        total++;
        if (sticky_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL add_no_sticky got=%b exp=0", sticky_err);
        end
        run_op(8'h7F, 8'h01, 3'b000, 1'b0, r, f, lat);
        total++;
`ifdef SAFE_ALU_SATURATE_EN
        if ({r, f} !== {8'h7F, 5'b00010}) begin
            bad++;
            $display("[TB] FAIL add_ovf got r=%h f=%b exp r=7f f=00010", r, f);
        end
`else
        if ({r, f} !== {8'h80, 5'b01010}) begin
            bad++;
            $display("[TB] FAIL add_ovf got r=%h f=%b exp r=80 f=01010", r, f);
        end
`endif
        total++;
        if (sticky_err !== 1'b1) begin
            bad++;
            $display("[TB] FAIL add_ovf_sticky got=%b exp=1", sticky_err);
        end
        total++;
        if (op_count !== 16'd3) begin
            bad++;
            $display("[TB] FAIL add_count got=%0d exp=3", op_count);
        end
    endtask

    task automatic test_sub();
        logic [7:0] r;
        logic [4:0] f;
        int         lat;
        run_op(8'd10, 8'd10, 3'b001, 1'b0, r, f, lat);
        total++;
        if ({r, f} !== {8'h00, 5'b10000}) begin
            bad++;
            $display("[TB] FAIL sub_10_10 got r=%h f=%b exp r=00 f=10000", r, f);
        end
        run_op(8'd5, 8'd6, 3'b001, 1'b0, r, f, lat);
        total++;
        if ({r, f} !== {8'hFF, 5'b01100}) begin
            bad++;
            $display("[TB] FAIL sub_5_6 got r=%h f=%b exp r=ff f=01100", r, f);
        end
        run_op(8'h80, 8'h01, 3'b001, 1'b0, r, f, lat);
        total++;
`ifdef SAFE_ALU_SATURATE_EN
        if ({r, f} !== {8'h80, 5'b01010}) begin
            bad++;
            $display("[TB] FAIL sub_ovf got r=%h f=%b exp r=80 f=01010", r, f);
        end
`else
        if ({r, f} !== {8'h7F, 5'b00010}) begin
            bad++;
            $display("[TB] FAIL sub_ovf got r=%h f=%b exp r=7f f=00010", r, f);
        end
`endif
    endtask

    task automatic test_logic();
        logic [7:0] r;
        logic [4:0] f;
        int         lat;
        run_op(8'hF0, 8'h3C, 3'b010, 1'b0, r, f, lat);
        total++;
        if ({r, f} !== {8'h30, 5'b00000}) begin
            bad++;
            $display("[TB] FAIL and got r=%h f=%b exp r=30 f=00000", r, f);
        end
        run_op(8'hF0, 8'h3C, 3'b011, 1'b0, r, f, lat);
        total++;
        if ({r, f} !== {8'hFC, 5'b01000}) begin
            bad++;
            $display("[TB] FAIL or got r=%h f=%b exp r=fc f=01000", r, f);
        end
        run_op(8'hF0, 8'h3C, 3'b100, 1'b0, r, f, lat);
        total++;
        if ({r, f} !== {8'hCC, 5'b01000}) begin
            bad++;
            $display("[TB] FAIL xor got r=%h f=%b exp r=cc f=01000", r, f);
        end
    endtask

    task automatic test_shift();
        logic [7:0] r;
        logic [4:0] f;
        int         lat;
        run_op(8'h81, 8'd1, 3'b101, 1'b0, r, f, lat);
        total++;
        if ({r, f} !== {8'h02, 5'b00100}) begin
            bad++;
            $display("[TB] FAIL shl_81_1 got r=%h f=%b exp r=02 f=00100", r, f);
        end
        run_op(8'h01, 8'd1, 3'b110, 1'b0, r, f, lat);
        total++;
        if ({r, f} !== {8'h00, 5'b10100}) begin
            bad++;
            $display("[TB] FAIL shr_01_1 got r=%h f=%b exp r=00 f=10100", r, f);
        end
        // b=8 -> shift amount 0 (only low 3 bits used)
        run_op(8'hA5, 8'h08, 3'b101, 1'b0, r, f, lat);
        total++;
        if ({r, f} !== {8'hA5, 5'b01000}) begin
            bad++;
            $display("[TB] FAIL shl_by0 got r=%h f=%b exp r=a5 f=01000", r, f);
        end
        run_op(8'h03, 8'd7, 3'b101, 1'b0, r, f, lat);
        total++;
        if ({r, f} !== {8'h80, 5'b01100}) begin
            bad++;
            $display("[TB] FAIL shl_03_7 got r=%h f=%b exp r=80 f=01100", r, f);
        end
        run_op(8'h80, 8'd7, 3'b110, 1'b0, r, f, lat);
        total++;
        if ({r, f} !== {8'h01, 5'b00000}) begin
            bad++;
            $display("[TB] FAIL shr_80_7 got r=%h f=%b exp r=01 f=00000", r, f);
        end
    endtask

    task automatic test_illegal_sticky();
        logic [7:0] r;
        logic [4:0] f;
        int         lat;
        // clear alone (sticky is set from the earlier overflow tests)
        @(negedge clk);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        total++;
        if (sticky_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clr_alone got=%b exp=0", sticky_err);
        end
        run_op(8'h05, 8'h03, 3'b111, 1'b0, r, f, lat);
        total++;
        if ({r, f} !== {8'h00, 5'b10001}) begin
            bad++;
            $display("[TB] FAIL illegal got r=%h f=%b exp r=00 f=10001", r, f);
        end
        total++;
        if (sticky_err !== 1'b1) begin
            bad++;
            $display("[TB] FAIL illegal_sticky got=%b exp=1", sticky_err);
        end
        // clear together with a non-setting accept -> cleared
        run_op(8'd1, 8'd1, 3'b000, 1'b1, r, f, lat);
        total++;
        if (sticky_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clr_with_clean_accept got=%b exp=0", sticky_err);
        end
        // clear together with a setting accept -> set wins
        run_op(8'h00, 8'h00, 3'b111, 1'b1, r, f, lat);
        total++;
        if (sticky_err !== 1'b1) begin
            bad++;
            $display("[TB] FAIL clr_with_setting_accept got=%b exp=1", sticky_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [4];
        logic [7:0] got_q [$];
        logic [7:0] held;
        int         sent;
        bit         saw_not_ready;
        bit         have_held;
        exp_q = '{8'h03, 8'h14, 8'h25, 8'h36};
        sent = 0;
        saw_not_ready = 1'b0;
        have_held = 1'b0;
        held = '0;
        do_reset();
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (sent < 4) begin
                in_valid = 1'b1;
                a        = 8'((sent << 4) + 1);
                b        = 8'(sent + 2);
                opcode   = 3'b000;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && !in_ready) saw_not_ready = 1'b1;
            if (out_valid && !out_ready) begin
                if (!have_held) begin
                    held = result;
                    have_held = 1'b1;
                end else begin
                    total++;
                    if (result !== held) begin
                        bad++;
                        $display("[TB] FAIL b2b_stall_stable got=%h exp=%h", result, held);
                    end
                end
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) got_q.push_back(result);
            if (got_q.size() >= 4) break;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (!saw_not_ready) begin
            bad++;
            $display("[TB] FAIL b2b_in_ready_drop got=never_low exp=low_during_stall");
        end
        total++;
        if (got_q.size() !== 4) begin
            bad++;
            $display("[TB] FAIL b2b_count got=%0d exp=4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("[TB] FAIL b2b_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        total++;
        if (op_count !== 16'd4) begin
            bad++;
            $display("[TB] FAIL b2b_op_count got=%0d exp=4", op_count);
        end
    endtask

    task automatic test_reset_midflight();
        logic [7:0] r;
        logic [4:0] f;
        int         lat;
        bit         stray;
        do_reset();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'd11; b = 8'd22; opcode = 3'b000;
        @(negedge clk);
        a = 8'd33; b = 8'd44;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({out_valid, in_ready, op_count} !== {1'b0, 1'b0, 16'd0}) begin
            bad++;
            $display("[TB] FAIL midflight_rst got ov=%b ir=%b cnt=%0d exp ov=0 ir=0 cnt=0",
                     out_valid, in_ready, op_count);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (out_valid) stray = 1'b1;
        end
        total++;
        if (stray !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midflight_dropped got=stray_beat exp=none");
        end
        run_op(8'd3, 8'd4, 3'b000, 1'b0, r, f, lat);
        total++;
        if ({r, f, lat} !== {8'd7, 5'b00000, 32'd2}) begin
            bad++;
            $display("[TB] FAIL post_rst_beat got r=%h f=%b lat=%0d exp r=07 f=00000 lat=2", r, f, lat);
        end
        total++;
        if (op_count !== 16'd1) begin
            bad++;
            $display("[TB] FAIL post_rst_count got=%0d exp=1", op_count);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        opcode     = '0;
        out_ready  = 1'b1;
        clr_sticky = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_shift();
        test_illegal_sticky();
        test_back_to_back();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
